risc16_mem: RTL and testbench
=============================

Name: risc16_mem

Overview:
- Memory-side responder for the RISC16 core. It serves the core's instruction-fetch port and data port from one word-organised RAM.
- The instruction port is read-only. The data port supports word reads and writes, plus per-byte writes through lane enables.
- It also contains a host program loader. The loader holds the core in reset, streams a word image into RAM from word address 0, then releases the core so it starts at PC 0.
- Sits between the testbench/host and the core in the top-level system.

Parameters:
- MEM_WORDS, 32768, number of 16-bit words; must be a power of two. Byte addresses wrap modulo 2*MEM_WORDS.
- BOOT_RUN, 0, 1 = leave reset directly in RUN (RAM is pre-initialised); 0 = leave reset in WAIT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- i_addr  in  16  instruction byte address from core; bit 0 ignored
- i_oe  in  1  instruction read enable
- i_din  out  16  instruction word to core
- d_addr  in  16  data byte address; bit 0 ignored for reads
- d_oe  in  1  data read enable
- d_din  out  16  read data to core
- d_dout  in  16  write data from core
- d_we  in  2  byte-lane write enable: bit0 → bits[15:8] (even byte), bit1 → bits[7:0] (odd byte)
- ld_start  in  1  one-cycle pulse: begin (or restart) a load
- ld_valid  in  1  load word valid
- ld_data  in  16  load word
- ld_last  in  1  marks the final word of the image
- ld_ready  out  1  loader accepts the word this cycle
- cpu_rst  out  1  reset to the core; synchronous active-high
- ld_count  out  16  number of words accepted in the current/last load
- ld_sum  out  16  mod-2^16 sum of the words accepted in the current/last load
- ld_ovf  out  1  sticky flag: the load address wrapped past MEM_WORDS-1

Behaviour:
- Word index = addr[$clog2(MEM_WORDS):1].
- Reads are combinational:
  - i_din = mem[i_addr index] when i_oe=1, else 0.
  - d_din = mem[d_addr index] when d_oe=1, else 0.
- Writes occur at posedge clk. A same-cycle read returns the old contents.
- Data write: for each set bit of d_we, that lane of d_dout is written; the other lane is unchanged. d_we=2'b00 writes nothing.
- d_we is honoured only in state RUN; in all other states it is masked to 0.
- States:
  - WAIT: cpu_rst=1, ld_ready=0.
  - LOAD: cpu_rst=1, ld_ready=!ld_start.
  - RELEASE: cpu_rst=1, ld_ready=0; lasts exactly 1 cycle.
  - RUN: cpu_rst=0, ld_ready=0.
- Transitions:
  - rst → WAIT, or RUN if BOOT_RUN=1.
  - ld_start in any state → LOAD. The load word address, ld_count, ld_sum and ld_ovf are all cleared to 0.
  - LOAD with ld_valid & ld_ready: write ld_data to mem[addr] and increment addr (wrapping MEM_WORDS-1→0, which sets ld_ovf). Also increment ld_count and add ld_data to ld_sum, both mod 2^16.
  - If that accepted word has ld_last=1, go to RELEASE. RELEASE always goes to RUN.
- ld_start has priority over ld_valid in the same cycle: the word is not accepted.
- ld_start while in RUN returns the core to reset on the next cycle. This is how a reload mid-run is done.
- Reset values: cpu_rst=1, ld_ready=0, ld_count=0, ld_sum=0, ld_ovf=0.
  - With BOOT_RUN=1, cpu_rst is 0 from the first cycle after reset.
- Reset does not clear RAM contents.
- Latency: the core's first fetch (PC 0) happens on the first RUN cycle, 2 cycles after the word with ld_last is accepted.

Optional Feature:
- Macro RISC16_MEM_MMIO_EN.
- When defined:
  - Adds output port mmio_out [15:0], reset 0.
  - In RUN, a write with d_addr==16'hFFFE and d_we==2'b11 loads d_dout into mmio_out and does not write RAM.
  - A read of d_addr 16'hFFFE with d_oe=1 returns mmio_out.
  - A byte write to 16'hFFFE/16'hFFFF goes to RAM.
- When undefined: no port; 16'hFFFE is ordinary RAM (wrapped).

Decomposition:
- Package risc16_mem_pkg holds:
  - the state enum typedef (WAIT, LOAD, RELEASE, RUN);
  - the MMIO address constant 16'hFFFE;
  - the lane mapping constants.
- One sub-module, risc16_mem_ram: MEM_WORDS x 16, two combinational read ports, one write port with 2-bit lane enables.
- The loader FSM and muxing stay in the top.

Test Plan:
- Reset with BOOT_RUN=0, no stimulus for 10 cycles → cpu_rst=1, ld_ready=0, ld_count=0 throughout.
- ld_start, then 3 words 16'h1111, 16'h2222, 16'h3333 (last on the third) → ld_count=3, ld_sum=16'h6666, cpu_rst falls exactly 2 cycles after the third is accepted, i_addr=0 reads 16'h1111, i_addr=4 reads 16'h3333.
- In RUN, d_addr=16'h0010, d_we=2'b11, d_dout=16'hABCD, then d_we=2'b01 with d_dout=16'h5500 → d_oe read returns 16'h55CD; d_we=2'b10 with d_dout=16'h0077 on d_addr=16'h0011 → 16'h5577.
- Mid-load ld_start asserted together with ld_valid after 2 words → that word is rejected (ld_ready=0), and ld_count/ld_sum/addr restart at 0; a subsequent single last-word 16'hBEEF lands at word 0.
- MEM_WORDS=16: stream 17 words, last word 16'h00AA → ld_ovf=1, word 0 reads 16'h00AA.
- With RISC16_MEM_MMIO_EN: sw 16'h1234 to 16'hFFFE → mmio_out=16'h1234 and RAM word at the same (wrapped) index unchanged; without the macro the RAM word reads 16'h1234.

Source files
------------

// File: rtl/risc16_mem_pkg.sv
// Shared types and constants for the RISC16 memory responder.
// Optional MMIO register is enabled by defining RISC16_MEM_MMIO_EN.
package risc16_mem_pkg;

  // Loader / core-reset sequencing states
  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  // Data-port address that maps to the output register when MMIO is built in
  localparam logic [15:0] MMIO_ADDR = 16'hFFFE;

  // Lane enable bit positions: big-endian bytes, even byte lives in [15:8]
  localparam int LANE_EVEN = 0;
  localparam int LANE_ODD  = 1;
  localparam int NUM_LANES = 2;

  // Most significant bit of the 8-bit slice written by a given lane enable
  function automatic int lane_msb(input int lane);
    return 15 - 8 * lane;
  endfunction

endpackage

// File: rtl/risc16_mem_ram.sv
// Word-organised RAM: two combinational read ports, one byte-lane write port.
// Stored as one byte array per lane so each lane has an independent writer.
module risc16_mem_ram
  import risc16_mem_pkg::*;
#(
  parameter int MEM_WORDS = 32768,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] ra_addr_i,
  output logic [15:0]   ra_data_o,
  input  logic [AW-1:0] rb_addr_i,
  output logic [15:0]   rb_data_o,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [15:0]   wr_data_i,
  input  logic [1:0]    wr_en_i
);

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [7:0] mem_q [MEM_WORDS];

    // Write this lane's byte when its enable is set; other lane untouched
    always_ff @(posedge clk) begin
      if (wr_en_i[gi]) begin
        mem_q[wr_addr_i] <= wr_data_i[lane_msb(gi) -: 8];
      end
    end

    assign ra_data_o[lane_msb(gi) -: 8] = mem_q[ra_addr_i];
    assign rb_data_o[lane_msb(gi) -: 8] = mem_q[rb_addr_i];
  end

endmodule

// File: rtl/risc16_mem.sv
// RISC16 memory responder: instruction/data ports over one RAM plus a host
// program loader that holds the core in reset while an image is streamed in.
// Define RISC16_MEM_MMIO_EN to add the mmio_out register at data address FFFE.
module risc16_mem
  import risc16_mem_pkg::*;
#(
  parameter int MEM_WORDS = 32768,
  parameter bit BOOT_RUN  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_addr,
  input  logic        i_oe,
  output logic [15:0] i_din,
  input  logic [15:0] d_addr,
  input  logic        d_oe,
  output logic [15:0] d_din,
  input  logic [15:0] d_dout,
  input  logic [1:0]  d_we,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [15:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        cpu_rst,
`ifdef RISC16_MEM_MMIO_EN
  output logic [15:0] mmio_out,
`endif
  output logic [15:0] ld_count,
  output logic [15:0] ld_sum,
  output logic        ld_ovf
);

  localparam int AW = $clog2(MEM_WORDS);

  state_e        state_q, state_d;
  logic [AW-1:0] ld_addr_q, ld_addr_d;
  logic [15:0]   count_q, count_d;
  logic [15:0]   sum_q, sum_d;
  logic          ovf_q, ovf_d;
  logic          accept;

  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic [1:0]    wr_en;
  logic [15:0]   ram_i_data, ram_d_data;

  // Word index drops the byte-select bit; high bits beyond AW wrap away
  logic [AW-1:0] i_idx, d_idx;
  assign i_idx = i_addr[AW:1];
  assign d_idx = d_addr[AW:1];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr, d_addr};

`ifdef RISC16_MEM_MMIO_EN
  logic [15:0] mmio_q, mmio_d;
  logic        mmio_hit;
  assign mmio_hit = (d_addr == MMIO_ADDR);
  assign mmio_out = mmio_q;
`endif

  // Loader FSM next state, counters and handshake outputs
  always_comb begin
    state_d   = state_q;
    ld_addr_d = ld_addr_q;
    count_d   = count_q;
    sum_d     = sum_q;
    ovf_d     = ovf_q;
    cpu_rst   = (state_q != ST_RUN);
    ld_ready  = (state_q == ST_LOAD) && !ld_start;
    accept    = ld_ready && ld_valid;

    if (ld_start) begin
      // Start or restart: also the way a running core is put back in reset
      state_d   = ST_LOAD;
      ld_addr_d = '0;
      count_d   = '0;
      sum_d     = '0;
      ovf_d     = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (accept) begin
            ld_addr_d = ld_addr_q + 1'b1;
            if (&ld_addr_q) ovf_d = 1'b1;
            count_d = count_q + 16'd1;
            sum_d   = sum_q + ld_data;
            if (ld_last) state_d = ST_RELEASE;
          end
        end
        ST_RELEASE: state_d = ST_RUN;
        default:    state_d = state_q;
      endcase
    end
  end

  // Single RAM write port: loader owns it in LOAD, the core's data port in RUN
  always_comb begin
    wr_addr = d_idx;
    wr_data = d_dout;
    wr_en   = 2'b00;
`ifdef RISC16_MEM_MMIO_EN
    mmio_d  = mmio_q;
`endif
    if (accept) begin
      wr_addr = ld_addr_q;
      wr_data = ld_data;
      wr_en   = 2'b11;
    end else if (state_q == ST_RUN) begin
      wr_en = d_we;
`ifdef RISC16_MEM_MMIO_EN
      // Only a full-word store hits the register; byte stores fall to RAM
      if (mmio_hit && d_we == 2'b11) begin
        wr_en  = 2'b00;
        mmio_d = d_dout;
      end
`endif
    end
  end

  // State and loader bookkeeping registers; RAM contents survive reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BOOT_RUN ? ST_RUN : ST_WAIT;
      ld_addr_q <= '0;
      count_q   <= '0;
      sum_q     <= '0;
      ovf_q     <= 1'b0;
`ifdef RISC16_MEM_MMIO_EN
      mmio_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ld_addr_q <= ld_addr_d;
      count_q   <= count_d;
      sum_q     <= sum_d;
      ovf_q     <= ovf_d;
`ifdef RISC16_MEM_MMIO_EN
      mmio_q    <= mmio_d;
`endif
    end
  end

  risc16_mem_ram #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_ram (
    .clk       (clk),
    .ra_addr_i (i_idx),
    .ra_data_o (ram_i_data),
    .rb_addr_i (d_idx),
    .rb_data_o (ram_d_data),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .wr_en_i   (wr_en)
  );

  // Read ports are combinational and return zero when not enabled
  always_comb begin
    i_din = i_oe ? ram_i_data : 16'h0000;
    d_din = d_oe ? ram_d_data : 16'h0000;
`ifdef RISC16_MEM_MMIO_EN
    if (d_oe && mmio_hit) d_din = mmio_q;
`endif
  end

  assign ld_count = count_q;
  assign ld_sum   = sum_q;
  assign ld_ovf   = ovf_q;

endmodule

// File: tb/tb_risc16_mem.sv
// Directed bench for risc16_mem: a full-size instance for load, data-port and
// MMIO behaviour, and a 16-word instance for load-address wrap.
module tb_risc16_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_addr, d_addr, d_dout, ld_data;
  logic        i_oe, d_oe, ld_start, ld_valid, ld_last;
  logic [1:0]  d_we;
  logic [15:0] i_din, d_din, ld_count, ld_sum;
  logic        ld_ready, cpu_rst, ld_ovf;

  logic [15:0] b_i_addr, b_ld_data;
  logic        b_ld_start, b_ld_valid, b_ld_last;
  logic [15:0] b_i_din, b_d_din, b_ld_count, b_ld_sum;
  logic        b_ld_ready, b_cpu_rst, b_ld_ovf;
`ifdef RISC16_MEM_MMIO_EN
  logic [15:0] mmio_out, b_mmio_out;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  risc16_mem #(.MEM_WORDS(32768), .BOOT_RUN(1'b0)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_oe(i_oe), .i_din(i_din),
    .d_addr(d_addr), .d_oe(d_oe), .d_din(d_din), .d_dout(d_dout), .d_we(d_we),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .cpu_rst(cpu_rst),
`ifdef RISC16_MEM_MMIO_EN
    .mmio_out(mmio_out),
`endif
    .ld_count(ld_count), .ld_sum(ld_sum), .ld_ovf(ld_ovf)
  );

  risc16_mem #(.MEM_WORDS(16), .BOOT_RUN(1'b0)) dut_small (
    .clk(clk), .rst(rst),
    .i_addr(b_i_addr), .i_oe(1'b1), .i_din(b_i_din),
    .d_addr(16'h0000), .d_oe(1'b0), .d_din(b_d_din), .d_dout(16'h0000), .d_we(2'b00),
    .ld_start(b_ld_start), .ld_valid(b_ld_valid), .ld_data(b_ld_data), .ld_last(b_ld_last),
    .ld_ready(b_ld_ready), .cpu_rst(b_cpu_rst),
`ifdef RISC16_MEM_MMIO_EN
    .mmio_out(b_mmio_out),
`endif
    .ld_count(b_ld_count), .ld_sum(b_ld_sum), .ld_ovf(b_ld_ovf)
  );

  typedef struct {
    logic [15:0] addr;
    logic [1:0]  we;
    logic [15:0] wdata;
    logic [15:0] raddr;
    logic [15:0] exp;
  } dvec_t;

  dvec_t vecs [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_word(input logic [15:0] w, input logic last);
    ld_valid = 1'b1;
    ld_data  = w;
    ld_last  = last;
    #1;
    chk("ld_ready_during_load", {15'd0, ld_ready}, 16'h0001);
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    $display("load word %h last=%0d count=%0d", w, last, ld_count);
  endtask

  initial begin
    vecs[0] = '{16'h0020, 2'b11, 16'hFFFF, 16'h0020, 16'hFFFF};
    vecs[1] = '{16'h0021, 2'b11, 16'h1357, 16'h0020, 16'h1357};
    vecs[2] = '{16'h0020, 2'b00, 16'h0000, 16'h0020, 16'h1357};
    vecs[3] = '{16'h0021, 2'b10, 16'h0042, 16'h0021, 16'h1342};
    vecs[4] = '{16'h0010, 2'b11, 16'hABCD, 16'h0010, 16'hABCD};
    vecs[5] = '{16'h0010, 2'b01, 16'h5500, 16'h0010, 16'h55CD};
    vecs[6] = '{16'h0011, 2'b10, 16'h0077, 16'h0011, 16'h5577};

    rst = 1'b1;
    i_addr = '0; d_addr = '0; d_dout = '0; ld_data = '0;
    i_oe = 1'b0; d_oe = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    d_we = 2'b00;
    b_i_addr = '0; b_ld_data = '0; b_ld_start = 1'b0; b_ld_valid = 1'b0; b_ld_last = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Idle after reset: core held, loader not ready, nothing counted
    for (int c = 0; c < 10; c++) begin
      step();
      chk("idle_cpu_rst", {15'd0, cpu_rst}, 16'h0001);
      chk("idle_ld_ready", {15'd0, ld_ready}, 16'h0000);
      chk("idle_ld_count", ld_count, 16'h0000);
    end
    chk("reset_ld_sum", ld_sum, 16'h0000);
    chk("reset_ld_ovf", {15'd0, ld_ovf}, 16'h0000);
`ifdef RISC16_MEM_MMIO_EN
    chk("reset_mmio_out", mmio_out, 16'h0000);
`endif

    // Three-word image
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    load_word(16'h1111, 1'b0);
    load_word(16'h2222, 1'b0);
    load_word(16'h3333, 1'b1);
    chk("release_cpu_rst", {15'd0, cpu_rst}, 16'h0001);
    chk("release_ld_ready", {15'd0, ld_ready}, 16'h0000);
    chk("load3_count", ld_count, 16'h0003);
    chk("load3_sum", ld_sum, 16'h6666);
    step();
    chk("run_cpu_rst", {15'd0, cpu_rst}, 16'h0000);
    i_oe = 1'b1;
    i_addr = 16'h0000; #1; chk("ifetch_w0", i_din, 16'h1111);
    i_addr = 16'h0003; #1; chk("ifetch_w1_odd", i_din, 16'h2222);
    i_addr = 16'h0004; #1; chk("ifetch_w2", i_din, 16'h3333);
    i_oe = 1'b0; #1; chk("ifetch_oe_off", i_din, 16'h0000);
    i_oe = 1'b1;

    // Data-port vector table
    for (int v = 0; v < 7; v++) begin
      d_addr = vecs[v].addr;
      d_we   = vecs[v].we;
      d_dout = vecs[v].wdata;
      d_oe   = 1'b0;
      step();
      d_we   = 2'b00;
      d_addr = vecs[v].raddr;
      d_oe   = 1'b1;
      #1;
      chk("dvec_read", d_din, vecs[v].exp);
      $display("vec %0d addr=%h we=%b wdata=%h read %h -> %h", v, vecs[v].addr,
               vecs[v].we, vecs[v].wdata, vecs[v].raddr, d_din);
    end
    d_oe = 1'b0; #1; chk("d_oe_off", d_din, 16'h0000);

    // Same-cycle read sees the old word; the new one appears after the edge
    d_addr = 16'h0010; d_oe = 1'b1; d_we = 2'b11; d_dout = 16'h9999;
    #1; chk("rd_during_wr_old", d_din, 16'h5577);
    step();
    d_we = 2'b00;
    #1; chk("rd_after_wr_new", d_din, 16'h9999);

    // Top-of-memory store: two byte stores then a full-word store to FFFE
    d_oe = 1'b0;
    d_addr = 16'hFFFE; d_we = 2'b01; d_dout = 16'hAA00; step();
    d_addr = 16'hFFFF; d_we = 2'b10; d_dout = 16'h00BB; step();
    d_addr = 16'hFFFE; d_we = 2'b11; d_dout = 16'h1234; step();
    d_we = 2'b00; d_oe = 1'b1; i_addr = 16'hFFFE;
    #1;
`ifdef RISC16_MEM_MMIO_EN
    chk("mmio_out", mmio_out, 16'h1234);
    chk("mmio_ram_untouched", i_din, 16'hAABB);
    chk("mmio_read", d_din, 16'h1234);
`else
    chk("ffe_ram_ifetch", i_din, 16'h1234);
    chk("ffe_ram_read", d_din, 16'h1234);
`endif
    $display("top store: i_din=%h d_din=%h", i_din, d_din);
    d_oe = 1'b0;

    // Reload from RUN, aborted by a second start that collides with a word
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    chk("reload_cpu_rst", {15'd0, cpu_rst}, 16'h0001);
    d_addr = 16'h0010; d_we = 2'b11; d_dout = 16'hFFFF;
    load_word(16'hAAAA, 1'b0);
    d_we = 2'b00;
    load_word(16'hBBBB, 1'b0);
    chk("abort_count2", ld_count, 16'h0002);
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 16'hCCCC; ld_last = 1'b1;
    #1; chk("start_blocks_ready", {15'd0, ld_ready}, 16'h0000);
    step();
    ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    chk("restart_count", ld_count, 16'h0000);
    chk("restart_sum", ld_sum, 16'h0000);
    chk("restart_cpu_rst", {15'd0, cpu_rst}, 16'h0001);
    load_word(16'hBEEF, 1'b1);
    chk("beef_count", ld_count, 16'h0001);
    chk("beef_sum", ld_sum, 16'hBEEF);
    step();
    step();
    chk("beef_run", {15'd0, cpu_rst}, 16'h0000);
    i_addr = 16'h0000; #1; chk("beef_w0", i_din, 16'hBEEF);
    i_addr = 16'h0002; #1; chk("aborted_w1", i_din, 16'hBBBB);
    d_addr = 16'h0010; d_oe = 1'b1; #1; chk("we_masked_in_load", d_din, 16'h9999);
    d_oe = 1'b0;

    // 16-word instance: 17 words wrap the load address
    b_ld_start = 1'b1;
    step();
    b_ld_start = 1'b0;
    for (int k = 0; k < 17; k++) begin
      b_ld_valid = 1'b1;
      b_ld_data  = (k == 16) ? 16'h00AA : 16'(k + 1);
      b_ld_last  = (k == 16);
      #1;
      chk("small_ready", {15'd0, b_ld_ready}, 16'h0001);
      if (k == 15) chk("small_ovf_before_wrap", {15'd0, b_ld_ovf}, 16'h0000);
      if (k == 16) chk("small_ovf_after_wrap", {15'd0, b_ld_ovf}, 16'h0001);
      step();
      $display("small load word %0d data=%h count=%0d", k, b_ld_data, b_ld_count);
    end
    b_ld_valid = 1'b0; b_ld_last = 1'b0;
    chk("small_count", b_ld_count, 16'h0011);
    chk("small_sum", b_ld_sum, 16'h0132);
    chk("small_ovf", {15'd0, b_ld_ovf}, 16'h0001);
    step();
    step();
    chk("small_run", {15'd0, b_cpu_rst}, 16'h0000);
    b_i_addr = 16'h0000; #1; chk("small_w0", b_i_din, 16'h00AA);
    b_i_addr = 16'h0002; #1; chk("small_w1", b_i_din, 16'h0002);
    b_i_addr = 16'h001E; #1; chk("small_w15", b_i_din, 16'h0010);
    b_i_addr = 16'h0020; #1; chk("small_addr_wrap", b_i_din, 16'h00AA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
